// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icodes, register ids, status codes and the E pipeline register layout.
package y86_pkg;
  localparam logic [3:0] I_HALT = 4'h0, I_NOP = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OP = 4'h6, I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8, I_RET = 4'h9, I_PUSH = 4'hA, I_POP = 4'hB;
  localparam logic [3:0] REG_RSP = 4'h4, REG_NONE = 4'hF;
  localparam logic [3:0] STAT_AOK = 4'b1000, STAT_HLT = 4'b0100, STAT_ADR = 4'b0010, STAT_INS = 4'b0001;
  typedef struct packed {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [63:0] val_c;
  } e_reg_t;
  localparam e_reg_t E_NOP = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0, src_a: REG_NONE,
                               src_b: REG_NONE, dst_e: REG_NONE, dst_m: REG_NONE,
                               val_a: 64'd0, val_b: 64'd0, val_c: 64'd0};
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: 15x64 register file, two combinational reads, two posedge writes (port M wins), preset on reset.
module y86_regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] init [15],
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m,
  output logic [63:0] rd_a,
  output logic [63:0] rd_b,
  output logic [63:0] regs [15]
);
  assign rd_a = (src_a == REG_NONE) ? 64'd0 : regs[src_a];
  assign rd_b = (src_b == REG_NONE) ? 64'd0 : regs[src_b];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= init;
    else begin
      if (dst_e != REG_NONE) regs[dst_e] <= val_e;
      if (dst_m != REG_NONE) regs[dst_m] <= val_m;
    end
  end
endmodule

// File: rtl/pipe_decode.sv
// pipe_decode: Y86-64 decode/write-back stage with E/M/W forwarding and the E pipeline register.
// Optional PIPE_DECODE_TRACE_EN prints write-back and bubble events in simulation.
module pipe_decode
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic        E_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic [63:0] in_reg0, in_reg1, in_reg2, in_reg3, in_reg4,
  input  logic [63:0] in_reg5, in_reg6, in_reg7, in_reg8, in_reg9,
  input  logic [63:0] in_reg10, in_reg11, in_reg12, in_reg13, in_reg14,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [63:0] E_valC,
  output logic [63:0] reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4,
  output logic [63:0] reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9,
  output logic [63:0] reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14
);
  logic [63:0] init [15];
  logic [63:0] regs [15];
  logic [63:0] rd_a, rd_b;
  logic [3:0]  d_dst_e, d_dst_m;
  e_reg_t      d_e, e_q;
  logic        unused_w_icode;
  assign unused_w_icode = ^W_icode;
  assign init = '{in_reg0, in_reg1, in_reg2, in_reg3, in_reg4, in_reg5, in_reg6, in_reg7,
                  in_reg8, in_reg9, in_reg10, in_reg11, in_reg12, in_reg13, in_reg14};
  y86_regfile u_rf (
    .clk(clk), .rst_n(rst_n), .init(init),
    .src_a(d_srcA), .src_b(d_srcB),
    .dst_e(W_dstE), .val_e(W_valE), .dst_m(W_dstM), .val_m(W_valM),
    .rd_a(rd_a), .rd_b(rd_b), .regs(regs)
  );
  assign d_srcA = (D_icode inside {I_CMOV, I_RMMOV, I_OP, I_PUSH}) ? D_rA :
                  (D_icode inside {I_RET, I_POP}) ? REG_RSP : REG_NONE;
  assign d_srcB = (D_icode inside {I_RMMOV, I_MRMOV, I_OP}) ? D_rB :
                  (D_icode inside {I_CALL, I_RET, I_PUSH, I_POP}) ? REG_RSP : REG_NONE;
  assign d_dst_e = (D_icode inside {I_CMOV, I_IRMOV, I_OP}) ? D_rB :
                   (D_icode inside {I_CALL, I_RET, I_PUSH, I_POP}) ? REG_RSP : REG_NONE;
  assign d_dst_m = (D_icode inside {I_MRMOV, I_POP}) ? D_rA : REG_NONE;
  // Youngest producer wins; M_dstM precedes M_dstE so a load result beats the ALU result.
  function automatic logic [63:0] fwd(input logic [3:0] s, input logic [63:0] rf);
    return (s == REG_NONE) ? 64'd0 : (s == e_dstE) ? e_valE : (s == M_dstM) ? m_valM :
           (s == M_dstE) ? M_valE : (s == W_dstM) ? W_valM : (s == W_dstE) ? W_valE : rf;
  endfunction
  always_comb begin
    d_e = '{stat: D_stat, icode: D_icode, ifun: D_ifun, src_a: d_srcA, src_b: d_srcB,
            dst_e: d_dst_e, dst_m: d_dst_m, val_a: 64'd0, val_b: fwd(d_srcB, rd_b), val_c: D_valC};
    d_e.val_a = (D_icode inside {I_JXX, I_CALL}) ? D_valP : fwd(d_srcA, rd_a);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= E_NOP;
    else e_q <= E_bubble ? E_NOP : d_e;
  end
  assign {E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM, E_valA, E_valB, E_valC} = e_q;
  assign {reg_mem0, reg_mem1, reg_mem2, reg_mem3, reg_mem4} = {regs[0], regs[1], regs[2], regs[3], regs[4]};
  assign {reg_mem5, reg_mem6, reg_mem7, reg_mem8, reg_mem9} = {regs[5], regs[6], regs[7], regs[8], regs[9]};
  assign {reg_mem10, reg_mem11, reg_mem12, reg_mem13, reg_mem14} = {regs[10], regs[11], regs[12], regs[13], regs[14]};
`ifdef PIPE_DECODE_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n && W_dstE != REG_NONE) $display("WB r%0d=%0d", W_dstE, W_valE);
    if (rst_n && W_dstM != REG_NONE) $display("WB r%0d=%0d", W_dstM, W_valM);
    if (rst_n && E_bubble) $display("E bubble");
  end
`endif
endmodule

// File: tb/tb_pipe_decode.sv
// tb_pipe_decode: directed stimulus, cycle-by-cycle comparison against a behavioural decode model.
module tb_pipe_decode;
  logic clk, rst_n, E_bubble, go;
  logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB, e_dstE, M_dstE, M_dstM, W_icode, W_dstE, W_dstM;
  logic [63:0] D_valC, D_valP, e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [63:0] in_reg [15];
  logic [63:0] reg_mem [15];
  logic [3:0] d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [63:0] mr [15];
  logic [3:0] x_stat, x_icode, x_ifun, x_srcA, x_srcB, x_dstE, x_dstM;
  logic [63:0] x_valA, x_valB, x_valC;
  int checks = 0, failures = 0;

  pipe_decode dut (
    .clk(clk), .rst_n(rst_n), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .E_bubble(E_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM),
    .m_valM(m_valM), .W_icode(W_icode), .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM),
    .W_valM(W_valM),
    .in_reg0(in_reg[0]), .in_reg1(in_reg[1]), .in_reg2(in_reg[2]), .in_reg3(in_reg[3]),
    .in_reg4(in_reg[4]), .in_reg5(in_reg[5]), .in_reg6(in_reg[6]), .in_reg7(in_reg[7]),
    .in_reg8(in_reg[8]), .in_reg9(in_reg[9]), .in_reg10(in_reg[10]), .in_reg11(in_reg[11]),
    .in_reg12(in_reg[12]), .in_reg13(in_reg[13]), .in_reg14(in_reg[14]),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .reg_mem0(reg_mem[0]), .reg_mem1(reg_mem[1]), .reg_mem2(reg_mem[2]), .reg_mem3(reg_mem[3]),
    .reg_mem4(reg_mem[4]), .reg_mem5(reg_mem[5]), .reg_mem6(reg_mem[6]), .reg_mem7(reg_mem[7]),
    .reg_mem8(reg_mem[8]), .reg_mem9(reg_mem[9]), .reg_mem10(reg_mem[10]), .reg_mem11(reg_mem[11]),
    .reg_mem12(reg_mem[12]), .reg_mem13(reg_mem[13]), .reg_mem14(reg_mem[14])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // Instruction-class tables from the ISA.
  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    case (ic)
      4'h2, 4'h4, 4'h6, 4'hA: return ra;
      4'h9, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h4, 4'h5, 4'h6: return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction
  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    case (ic)
      4'h2, 4'h3, 4'h6: return rb;
      4'h8, 4'h9, 4'hA, 4'hB: return 4'h4;
      default: return 4'hF;
    endcase
  endfunction
  function automatic logic [63:0] m_fwd(input logic [3:0] s);
    logic [3:0] d [5];
    logic [63:0] v [5];
    d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s == 4'hF) return 64'd0;
    for (int i = 0; i < 5; i++) if (d[i] == s) return v[i];
    return mr[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) mr[i] <= in_reg[i];
      {x_stat, x_icode, x_ifun} <= {4'b1000, 4'h1, 4'h0};
      {x_srcA, x_srcB, x_dstE, x_dstM} <= 16'hFFFF;
      {x_valA, x_valB, x_valC} <= '0;
    end else begin
      if (E_bubble) begin
        {x_stat, x_icode, x_ifun} <= {4'b1000, 4'h1, 4'h0};
        {x_srcA, x_srcB, x_dstE, x_dstM} <= 16'hFFFF;
        {x_valA, x_valB, x_valC} <= '0;
      end else begin
        {x_stat, x_icode, x_ifun} <= {D_stat, D_icode, D_ifun};
        x_srcA <= m_srcA(D_icode, D_rA);
        x_srcB <= m_srcB(D_icode, D_rB);
        x_dstE <= m_dstE(D_icode, D_rB);
        x_dstM <= (D_icode == 4'h5 || D_icode == 4'hB) ? D_rA : 4'hF;
        x_valA <= (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : m_fwd(m_srcA(D_icode, D_rA));
        x_valB <= m_fwd(m_srcB(D_icode, D_rB));
        x_valC <= D_valC;
      end
      if (W_dstE != 4'hF) mr[W_dstE] <= W_valE;
      if (W_dstM != 4'hF) mr[W_dstM] <= W_valM;
    end
  end

  always @(negedge clk) begin
    if (go) begin
      chk("d_srcA", d_srcA, m_srcA(D_icode, D_rA));
      chk("d_srcB", d_srcB, m_srcB(D_icode, D_rB));
      chk("E_stat", E_stat, x_stat);
      chk("E_icode", E_icode, x_icode);
      chk("E_ifun", E_ifun, x_ifun);
      chk("E_srcA", E_srcA, x_srcA);
      chk("E_srcB", E_srcB, x_srcB);
      chk("E_dstE", E_dstE, x_dstE);
      chk("E_dstM", E_dstM, x_dstM);
      chk("E_valA", E_valA, x_valA);
      chk("E_valB", E_valB, x_valB);
      chk("E_valC", E_valC, x_valC);
      for (int i = 0; i < 15; i++) chk($sformatf("reg_mem%0d", i), reg_mem[i], mr[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  task automatic idle();
    {D_stat, D_icode, D_ifun, D_rA, D_rB} = {4'b1000, 4'h1, 4'h0, 4'hF, 4'hF};
    {D_valC, D_valP} = '0;
    E_bubble = 0;
    {e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, W_icode} = {4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h1};
    {e_valE, M_valE, m_valM, W_valE, W_valM} = '0;
  endtask
  task automatic instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    {D_icode, D_rA, D_rB, D_valC, D_valP} = {ic, ra, rb, vc, vp};
  endtask

  initial begin
    go = 0;
    rst_n = 0;
    for (int i = 0; i < 15; i++) in_reg[i] = 64'h100 + 64'(i);
    in_reg[1] = 5;
    in_reg[2] = 9;
    in_reg[3] = 7;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst reg_mem3", reg_mem[3], 64'd7);
    chk("rst E_icode", E_icode, 64'h1);
    chk("rst E_stat", E_stat, 64'h8);
    chk("rst E_dstE", E_dstE, 64'hF);
    rst_n = 1;
    go = 1;
    instr(4'h6, 4'h1, 4'h2, 64'd0, 64'd0);
    tick();
    chk("op E_valA", E_valA, 64'd5);
    chk("op E_valB", E_valB, 64'd9);
    chk("op E_dstE", E_dstE, 64'd2);
    chk("op E_srcA", E_srcA, 64'd1);
    {e_dstE, e_valE, M_dstE, M_valE} = {4'h1, 64'd42, 4'h1, 64'd11};
    tick();
    chk("fwd e E_valA", E_valA, 64'd42);
    chk("fwd e E_valB", E_valB, 64'd9);
    {e_dstE, M_dstM, m_valM, M_dstE, M_valE} = {4'hF, 4'h2, 64'd77, 4'h2, 64'd66};
    tick();
    chk("fwd mM E_valB", E_valB, 64'd77);
    chk("fwd mM E_valA", E_valA, 64'd5);
    idle();
    instr(4'h8, 4'hF, 4'hF, 64'h123, 64'h40);
    #1;
    chk("call d_srcB", d_srcB, 64'h4);
    tick();
    chk("call E_valA", E_valA, 64'h40);
    chk("call E_dstE", E_dstE, 64'h4);
    chk("call E_valB", E_valB, 64'h104);
    instr(4'h9, 4'hF, 4'hF, 64'd0, 64'h50);
    #1;
    chk("ret d_srcA", d_srcA, 64'h4);
    chk("ret d_srcB", d_srcB, 64'h4);
    tick();
    instr(4'hB, 4'h5, 4'hF, 64'd0, 64'd0);
    tick();
    chk("pop E_dstM", E_dstM, 64'h5);
    chk("pop E_valA", E_valA, 64'h104);
    instr(4'h6, 4'h3, 4'hF, 64'd0, 64'd0);
    {W_dstE, W_valE, W_dstM, W_valM} = {4'h3, 64'd1, 4'h3, 64'd2};
    tick();
    chk("wb reg_mem3", reg_mem[3], 64'd2);
    chk("wb fwd E_valA", E_valA, 64'd2);
    {W_dstE, W_dstM} = 8'hFF;
    tick();
    chk("rf E_valA", E_valA, 64'd2);
    {W_dstE, W_valE, W_dstM, W_valM} = {4'h7, 64'hAB, 4'hF, 64'hCD};
    tick();
    chk("wbE reg_mem7", reg_mem[7], 64'hAB);
    {W_dstE, W_dstM} = 8'hFF;
    instr(4'h6, 4'h1, 4'h2, 64'd0, 64'd0);
    E_bubble = 1;
    tick();
    chk("bub E_icode", E_icode, 64'h1);
    chk("bub E_valA", E_valA, 64'd0);
    chk("bub E_dstE", E_dstE, 64'hF);
    E_bubble = 0;
    tick();
    chk("post bub E_valA", E_valA, 64'd5);
    rst_n = 0;
    #2;
    chk("rst2 reg_mem3", reg_mem[3], 64'd7);
    chk("rst2 reg_mem7", reg_mem[7], 64'h107);
    chk("rst2 E_icode", E_icode, 64'h1);
    rst_n = 1;
    idle();
    instr(4'h3, 4'hF, 4'h9, 64'hBEEF, 64'd0);
    tick();
    chk("irmov E_valC", E_valC, 64'hBEEF);
    chk("irmov E_dstE", E_dstE, 64'h9);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
